// File: rtl/multi_rate_ticker_pkg.sv
// Shared types and helpers for multi_rate_ticker: channel state encoding,
// accumulator sizing and the target-rate clamp.
package ticker_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCEL = 3'd1,
    RUN   = 3'd2,
    DECEL = 3'd3,
    DRAIN = 3'd4
  } ticker_state_e;

  // One spare bit so acc + cur (cur <= clk_hz/2) never overflows before the wrap compare.
  function automatic int unsigned acc_width(input int unsigned clk_hz);
    return $clog2(clk_hz) + 1;
  endfunction

  // Capping at clk_hz/2 guarantees at least one low cycle between ticks.
  function automatic logic [31:0] clamp_rate(input logic [31:0] r, input int unsigned clk_hz);
    return (r > clk_hz / 2) ? clk_hz / 2 : r;
  endfunction

endpackage

// File: rtl/multi_rate_ticker_channel.sv
// One tick channel: phase accumulator, start/stop FSM and optional rate ramp.
// Ramp behaviour is compiled in with MULTI_RATE_TICKER_RAMP_EN.
//
// state | meaning
// IDLE  | stopped, cur/acc cleared, outputs low
// ACCEL | ramping cur up toward the target
// RUN   | cur equals the target
// DECEL | ramping cur down toward the target
// DRAIN | stop seen, ramping cur to 0 before returning to IDLE
module ticker_channel
  import ticker_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned RATE_W = 20
`ifdef MULTI_RATE_TICKER_RAMP_EN
  ,
  parameter int unsigned RAMP_STEP = 1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [RATE_W-1:0] rate,
`ifdef MULTI_RATE_TICKER_RAMP_EN
  input  logic              ramp_stb,
`endif
  output logic              tick,
  output logic              sq,
  output logic              running,
  output logic              done
);

  localparam int unsigned ACC_W = acc_width(CLK_HZ);
  localparam logic [ACC_W-1:0] FULL = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] HALF = ACC_W'(CLK_HZ / 2);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_RUN  = RUN;

  logic [2:0]        state;
  logic [RATE_W-1:0] cur;
  logic [ACC_W-1:0]  acc;
  logic [RATE_W-1:0] rate_c;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  acc_nx;
  logic              wrap;
  logic              go;
  logic              halt;

  always_comb begin
    rate_c = RATE_W'(clamp_rate(32'(rate), CLK_HZ));
    sum    = acc + ACC_W'(cur);
    wrap   = (sum >= FULL);
    acc_nx = wrap ? (sum - FULL) : sum;
    go     = start && !stop && (rate_c != '0);
    halt   = stop || (start && (rate_c == '0));
  end

  assign running = (state != S_IDLE);

`ifdef MULTI_RATE_TICKER_RAMP_EN
  localparam logic [2:0] S_ACCEL = ACCEL;
  localparam logic [2:0] S_DECEL = DECEL;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [RATE_W-1:0] STEP = RATE_W'(RAMP_STEP);

  logic [RATE_W-1:0] tgt;
  logic [RATE_W-1:0] goal;
  logic [RATE_W-1:0] cur_rmp;

  function automatic logic [2:0] run_state(input logic [RATE_W-1:0] c,
                                           input logic [RATE_W-1:0] t);
    if (c == t)     return S_RUN;
    else if (c < t) return S_ACCEL;
    else            return S_DECEL;
  endfunction

  always_comb begin
    goal    = (state == S_DRAIN) ? '0 : tgt;
    cur_rmp = cur;
    if (ramp_stb && (cur < goal))
      cur_rmp = ((goal - cur) > STEP) ? (cur + STEP) : goal;
    else if (ramp_stb && (cur > goal))
      cur_rmp = ((cur - goal) > STEP) ? (cur - STEP) : goal;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      tgt   <= '0;
      cur   <= '0;
      acc   <= '0;
      tick  <= 1'b0;
      sq    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      tick <= 1'b0;
      sq   <= 1'b0;
      if (state == S_IDLE) begin
        if (go) begin
          state <= S_ACCEL;
          tgt   <= rate_c;
          cur   <= '0;
          acc   <= '0;
        end
      end else if ((state == S_DRAIN) && (cur == '0) && !go) begin
        state <= S_IDLE;
        acc   <= '0;
        done  <= 1'b1;
      end else begin
        acc  <= acc_nx;
        tick <= wrap;
        sq   <= (acc_nx >= HALF);
        if (state == S_DRAIN) begin
          cur <= cur_rmp;
          if (go) begin
            tgt   <= rate_c;
            state <= run_state(cur_rmp, rate_c);
          end
        end else if (halt) begin
          state <= S_DRAIN;
        end else if (go) begin
          tgt   <= rate_c;
          cur   <= cur_rmp;
          state <= run_state(cur_rmp, rate_c);
        end else begin
          cur   <= cur_rmp;
          state <= run_state(cur_rmp, tgt);
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cur   <= '0;
      acc   <= '0;
      tick  <= 1'b0;
      sq    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        tick <= 1'b0;
        sq   <= 1'b0;
        if (go) begin
          state <= S_RUN;
          cur   <= rate_c;
          acc   <= '0;
        end
      end else if (halt) begin
        state <= S_IDLE;
        cur   <= '0;
        acc   <= '0;
        tick  <= 1'b0;
        sq    <= 1'b0;
        done  <= 1'b1;
      end else begin
        // Retarget keeps acc so the phase carries across the rate change.
        acc  <= acc_nx;
        tick <= wrap;
        sq   <= (acc_nx >= HALF);
        if (start) cur <= rate_c;
      end
    end
  end
`endif

endmodule

// File: rtl/multi_rate_ticker.sv
// Top of the multi-rate tick generator: per-channel port unpacking and the
// shared ramp strobe counter (present only with MULTI_RATE_TICKER_RAMP_EN).
module multi_rate_ticker
  import ticker_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned RATE_W    = 20,
  parameter int unsigned RAMP_DIV  = 500000,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        start,
  input  logic [CHANNELS-1:0]        stop,
  input  logic [CHANNELS*RATE_W-1:0] rate,
  output logic [CHANNELS-1:0]        tick,
  output logic [CHANNELS-1:0]        sq,
  output logic [CHANNELS-1:0]        running,
  output logic [CHANNELS-1:0]        done
);

`ifdef MULTI_RATE_TICKER_RAMP_EN
  localparam int unsigned DIV_W = $clog2(RAMP_DIV) + 1;

  logic [DIV_W-1:0] ramp_cnt;
  logic             ramp_stb;

  // Down-counter: strobe on terminal count, then reload for the next period.
  always_ff @(posedge clk) begin
    if (!rst)                 ramp_cnt <= '0;
    else if (ramp_cnt == '0)  ramp_cnt <= DIV_W'(RAMP_DIV - 1);
    else                      ramp_cnt <= ramp_cnt - 1'b1;
  end

  assign ramp_stb = (ramp_cnt == '0);
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ticker_channel #(
      .CLK_HZ   (CLK_HZ),
      .RATE_W   (RATE_W)
`ifdef MULTI_RATE_TICKER_RAMP_EN
      ,
      .RAMP_STEP(RAMP_STEP)
`endif
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .start   (start[i]),
      .stop    (stop[i]),
      .rate    (rate[i*RATE_W +: RATE_W]),
`ifdef MULTI_RATE_TICKER_RAMP_EN
      .ramp_stb(ramp_stb),
`endif
      .tick    (tick[i]),
      .sq      (sq[i]),
      .running (running[i]),
      .done    (done[i])
    );
  end

endmodule
